// File: rtl/bram_pkg.sv
// bram_pkg: shared write-mode and clear-sequencer types for the dual-port RAM bank
package bram_pkg;
  typedef enum logic [1:0] {WM_WRITE_FIRST, WM_READ_FIRST, WM_NO_CHANGE} wmode_e;
  typedef enum logic {CLEAR, READY} clr_state_e;
endpackage

// File: rtl/bram_out_pipe.sv
// bram_out_pipe: optional second output register stage for read data and valid
module bram_out_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             vin,
  output logic [WIDTH-1:0] dout,
  output logic             vout
);
  always_ff @(posedge clk) begin
    dout <= rst ? '0 : din;
    vout <= rst ? 1'b0 : vin;
  end
endmodule

// File: rtl/bram_bank_dp.sv
// bram_bank_dp: true-dual-port byte-enabled block RAM bank with post-reset clear sequencer
module bram_bank_dp
  import bram_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    DEPTH          = 1024,
  parameter wmode_e                WRITE_MODE     = WM_WRITE_FIRST,
  parameter int                    READ_LATENCY   = 1,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0,
  localparam int                   ADDR_WIDTH     = $clog2(DEPTH),
  localparam int                   NUM_BYTES      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_busy,
  input  logic                  a_en,
  input  logic [NUM_BYTES-1:0]  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  input  logic                  b_en,
  input  logic [NUM_BYTES-1:0]  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid,
  output logic                  collision
);
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
  clr_state_e state, state_n;
  logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_n;
  logic ready;
  logic [1:0] en, acc, wr, upd, v1, v2;
  logic [NUM_BYTES-1:0] we [2];
  logic [ADDR_WIDTH-1:0] addr [2];
  logic [DATA_WIDTH-1:0] din [2], old [2], nw [2], d1 [2], d2 [2];
  assign en = {b_en, a_en};
  assign we = '{a_we, b_we};
  assign addr = '{a_addr, b_addr};
  assign din = '{a_din, b_din};
  assign ready = state == READY;
  assign init_busy = !ready;
  always_ff @(posedge clk) begin
    state <= rst ? (CLEAR_ON_RESET ? CLEAR : READY) : state_n;
    clr_addr <= rst ? '0 : clr_addr_n;
  end
  always_comb begin
    state_n = (state == CLEAR && clr_addr == ADDR_WIDTH'(DEPTH - 1)) ? READY : state;
    clr_addr_n = (state == CLEAR) ? clr_addr + 1'b1 : clr_addr;
  end
  always_comb begin
    old = '{default: '0};
    nw = '{default: '0};
    acc = '0;
    wr = '0;
    upd = '0;
    for (int p = 0; p < 2; p++) begin
      old[p] = mem[addr[p]];
      for (int i = 0; i < NUM_BYTES; i++)
        nw[p][8*i +: 8] = we[p][i] ? din[p][8*i +: 8] : old[p][8*i +: 8];
      acc[p] = ready && en[p];
      wr[p] = acc[p] && |we[p];
      upd[p] = acc[p] && !(wr[p] && WRITE_MODE == WM_NO_CHANGE);
    end
  end
  always_ff @(posedge clk)
    if (!rst) begin
      if (!ready) mem[clr_addr] <= INIT_VALUE;
      for (int p = 1; p >= 0; p--)
        for (int i = 0; i < NUM_BYTES; i++)
          if (acc[p] && we[p][i]) mem[addr[p]][8*i +: 8] <= din[p][8*i +: 8];
    end
  always_ff @(posedge clk)
    if (rst) begin
      d1 <= '{default: '0};
      v1 <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        v1[p] <= upd[p];
        d1[p] <= !upd[p] ? d1[p] : (wr[p] && WRITE_MODE == WM_WRITE_FIRST) ? nw[p] : old[p];
      end
    end
  always_ff @(posedge clk)
    collision <= !rst && wr[0] && wr[1] && addr[0] == addr[1] && |(we[0] & we[1]);
  if (READ_LATENCY == 2) begin : g_pipe
    for (genvar p = 0; p < 2; p++) begin : g_port
      bram_out_pipe #(.WIDTH(DATA_WIDTH)) u_pipe (
        .clk(clk), .rst(rst), .din(d1[p]), .vin(v1[p]), .dout(d2[p]), .vout(v2[p])
      );
    end
  end else begin : g_direct
    assign d2 = d1;
    assign v2 = v1;
  end
  assign a_dout = d2[0];
  assign b_dout = d2[1];
  assign a_valid = v2[0];
  assign b_valid = v2[1];
endmodule
